mult_issue_ctrl: RTL and testbench
==================================

// Module: mult_issue_ctrl
// PURPOSE
//  Sequences the 64x64 multiplier datapath for the execute stage: accepts one MUL/MULW op per
//  valid/ready handshake, holds datapath operands stable for the full pipeline latency, and
//  captures the product. Returns a formatted 64-bit result on a valid/ready response channel.
//  Sits between the execute-stage issue logic and the multiplier top, which has no handshake.
// PARAMETERS
//  MUL_LATENCY  3   cycles from stable mul_a/mul_b to valid mul_c (datapath pipeline depth, >=1)
//  CNT_W        2   width of latency counter, >= $clog2(MUL_LATENCY+1)
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-low reset
//  flush          in   1   pipeline flush; squashes in-flight op
//  req_valid      in   1   request present
//  req_ready      out  1   controller can accept request
//  req_op         in   1   mult_op_t: MUL=0, MULW=1
//  req_signed     in   1   operands are signed
//  req_a, req_b   in   64  source operands
//  resp_valid     out  1   result valid
//  resp_ready     in   1   consumer takes result
//  resp_data      out  64  formatted result
//  mul_a, mul_b   out  64  datapath operands (registered)
//  mul_is_signed  out  1   datapath signed control (registered)
//  mul_c          in   64  datapath product (low 64 bits)
// BEHAVIOUR
//  - States: IDLE, BUSY, DONE. Reset (reset=0, async): state=IDLE, cnt=0, resp_valid=0,
//    resp_data=0, mul_a=mul_b=0, mul_is_signed=0; req_ready=1 once reset deasserts.
//  - req_ready = (state==IDLE | (state==DONE & resp_ready)) & ~flush. Accept = req_valid & req_ready.
//  - On accept: latch operands into mul_a/mul_b/mul_is_signed, latch op, cnt<=MUL_LATENCY-1,
//    state<=BUSY. MULW: mul_a/mul_b = sign-extended req_a[31:0]/req_b[31:0], mul_is_signed=1.
//  - BUSY: mul_* held constant; cnt decrements each cycle. When cnt==0: capture mul_c into
//    result register, state<=DONE. Op latency accept->resp_valid = MUL_LATENCY+1 cycles.
//  - DONE: resp_valid=1, resp_data stable until resp_ready. MUL: resp_data=product;
//    MULW: resp_data={{32{p[31]}},p[31:0]}. resp_ready & no accept -> IDLE, resp_valid=0.
//    resp_ready & accept same cycle -> back-to-back into BUSY; no idle bubble.
//  - flush (sync, highest priority): any state -> IDLE next cycle, resp_valid=0, cnt=0,
//    result discarded; req_valid in flush cycle not accepted. mul_* need not be cleared.
//  - resp_valid never asserts without a preceding accept; at most one op in flight.
//  - Product is low 64 bits only (MULH family not issued here; decode keeps it away).
//  - reset asserted mid-op: immediate return to reset values, op lost, no resp_valid.
// STRUCTURE
//  - Shared package mult_pkg: typedef enum logic {MUL, MULW} mult_op_t; typedef enum for
//    state (IDLE/BUSY/DONE); localparam MUL_LATENCY default; mult_req_t struct {op,signed,a,b}.
//  - One sub-module: mult_result_fmt (combinational; MULW sign-extend of raw product).
//    FSM, counter and operand registers stay in this module.
// TESTING
//  - Reset release, idle: req_ready=1, resp_valid=0, mul_a=0 for 10 cycles with no requests.
//  - MUL unsigned a=3,b=5, resp_ready=1 -> resp_valid exactly MUL_LATENCY+1 cycles after
//    accept, resp_data=15, req_ready=0 during BUSY, mul_a=3 held every BUSY cycle.
//  - MULW a=0x7FFF_FFFF,b=2 -> resp_data=0xFFFF_FFFF_FFFF_FFFE; MUL signed a=-1,b=7 ->
//    resp_data=0xFFFF_FFFF_FFFF_FFF9.
//  - Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_data stable, req_ready=0; then
//    resp_ready=1 with new req_valid (a=2,b=2) -> accepted same cycle, next resp_data=4.
//  - flush in 2nd BUSY cycle -> IDLE next cycle, no resp_valid for that op; following op
//    a=6,b=7 returns 42. flush with req_valid same cycle -> not accepted.
//  - reset pulsed low mid-BUSY (not clock-aligned) -> all outputs to reset values
//    immediately; after release next op a=9,b=9 returns 81.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier issue controller.
// Op encoding, controller states, request bundle and the 32-bit sign-extend helper.
package mult_pkg;

   typedef enum logic {
      MUL  = 1'b0,
      MULW = 1'b1
   } mult_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam int unsigned DEF_MUL_LATENCY = 3;
   localparam int unsigned DEF_CNT_W       = 2;

   typedef struct packed {
      mult_op_t    op;
      logic        is_signed;
      logic [63:0] a;
      logic [63:0] b;
   } mult_req_t;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/mult_result_fmt.sv
// Formats the raw low-64 product for the response channel.
// MULW results are the sign-extended low word; MUL passes the product through.
module mult_result_fmt
   import mult_pkg::*;
(
   input  mult_op_t    op,
   input  logic [63:0] raw,
   output logic [63:0] data
);

   always_comb begin
      data = raw;
      if (op == MULW) begin
         data = sext32(raw[31:0]);
      end
   end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/response controller for the handshake-less 64x64 multiplier datapath.
// One op in flight: operands held for MUL_LATENCY cycles, product captured, result returned.
module mult_issue_ctrl
   import mult_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = DEF_MUL_LATENCY,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  mult_op_t    req_op,
   input  logic        req_signed,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic [63:0] mul_a,
   output logic [63:0] mul_b,
   output logic        mul_is_signed,
   input  logic [63:0] mul_c
);

   mult_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      mul_a_q, mul_a_d;
   logic [63:0]      mul_b_q, mul_b_d;
   logic             mul_s_q, mul_s_d;
   mult_op_t         op_q, op_d;
   logic [63:0]      result_q, result_d;
   logic             accept;
   mult_req_t        req;

   assign req = '{op: req_op, is_signed: req_signed, a: req_a, b: req_b};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      mul_s_d  = mul_s_q;
      op_d     = op_q;
      result_d = result_q;

      req_ready = ((state_q == IDLE) || ((state_q == DONE) && resp_ready)) && !flush;
      accept    = req_valid && req_ready;

      if (flush) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = '0;
      end else begin
         case (state_q)
            IDLE: ;
            BUSY: begin
               if (cnt_q == '0) begin
                  result_d = mul_c;
                  state_d  = DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase

         // A DONE->BUSY accept overrides the drain to IDLE, giving back-to-back issue.
         if (accept) begin
            op_d    = req.op;
            state_d = BUSY;
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
            if (req.op == MULW) begin
               mul_a_d = sext32(req.a[31:0]);
               mul_b_d = sext32(req.b[31:0]);
               mul_s_d = 1'b1;
            end else begin
               mul_a_d = req.a;
               mul_b_d = req.b;
               mul_s_d = req.is_signed;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         mul_s_q  <= 1'b0;
         op_q     <= MUL;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         mul_s_q  <= mul_s_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   assign resp_valid    = (state_q == DONE);
   assign mul_a         = mul_a_q;
   assign mul_b         = mul_b_q;
   assign mul_is_signed = mul_s_q;

   mult_result_fmt u_fmt (
      .op   (op_q),
      .raw  (result_q),
      .data (resp_data)
   );

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: directed table, corner sequences and random traffic
// against a cycle-stamped transaction model of the controller.
module tb_mult_issue_ctrl;
   import mult_pkg::*;

   localparam int unsigned L = 3;

   logic        clk = 1'b0;
   logic        reset, flush, req_valid, req_ready, req_signed;
   logic        resp_valid, resp_ready, mul_is_signed;
   mult_op_t    req_op;
   logic [63:0] req_a, req_b, resp_data, mul_a, mul_b, mul_c;

   always #5 clk = ~clk;

   // datapath stand-in: product emerges L-1 registers after the operands
   logic [63:0] pipe [L-1];
   always @(posedge clk) begin
      pipe[0] <= mul_a * mul_b;
      for (int i = 1; i < int'(L) - 1; i++) pipe[i] <= pipe[i-1];
   end
   assign mul_c = pipe[L-2];

   mult_issue_ctrl #(.MUL_LATENCY(L), .CNT_W(2)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .mul_a(mul_a), .mul_b(mul_b), .mul_is_signed(mul_is_signed), .mul_c(mul_c)
   );

   int n_vec = 0, n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // transaction model: an accepted op becomes visible L+1 cycles after its accept cycle
   int          cyc;
   bit          inflight, rst_clean;
   int          due;
   logic [63:0] m_res, m_a, m_b;
   logic        m_s;
   logic        last_valid, last_ready;
   logic [63:0] last_data;

   function automatic logic [63:0] ref_result(mult_op_t op, logic [63:0] a, logic [63:0] b);
      logic [31:0] w;
      if (op == MULW) begin
         w = a[31:0] * b[31:0];
         return 64'($signed(w));
      end
      return a * b;
   endfunction

   task automatic model_reset();
      inflight  = 0;
      rst_clean = 1;
      m_a = '0; m_b = '0; m_s = 1'b0;
   endtask

   task automatic cyc_step();
      bit vis, eready;
      @(negedge clk);
      vis    = inflight && (cyc >= due);
      eready = (!inflight || (vis && resp_ready)) && !flush;
      chk("req_ready", 64'(req_ready), 64'(eready));
      chk("resp_valid", 64'(resp_valid), 64'(vis));
      if (vis) chk("resp_data", resp_data, m_res);
      if ((inflight && !vis) || rst_clean) begin
         chk("mul_a", mul_a, m_a);
         chk("mul_b", mul_b, m_b);
         chk("mul_is_signed", 64'(mul_is_signed), 64'(m_s));
      end
      last_valid = resp_valid;
      last_ready = req_ready;
      last_data  = resp_data;
      if (flush) begin
         inflight = 0;
      end else begin
         if (vis && resp_ready) inflight = 0;
         if (req_valid && eready) begin
            inflight  = 1;
            rst_clean = 0;
            due       = cyc + int'(L) + 1;
            m_res     = ref_result(req_op, req_a, req_b);
            m_a       = (req_op == MULW) ? 64'($signed(req_a[31:0])) : req_a;
            m_b       = (req_op == MULW) ? 64'($signed(req_b[31:0])) : req_b;
            m_s       = (req_op == MULW) ? 1'b1 : req_signed;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input mult_op_t op, input logic sgn, input logic [63:0] a, input logic [63:0] b);
      req_op = op; req_signed = sgn; req_a = a; req_b = b; req_valid = 1'b1;
   endtask

   task automatic wait_accept(input string name);
      bit acc = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
         cyc_step();
         acc = last_ready;
      end
      chk({name, " accept"}, 64'(acc), 64'd1);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string name, input logic [63:0] exp);
      bit          got = 0;
      int          lat = 0;
      logic [63:0] data = '0;
      for (int i = 0; i < int'(L) + 8 && !got; i++) begin
         cyc_step();
         lat++;
         got = last_valid;
         data = last_data;
      end
      chk({name, " resp seen"}, 64'(got), 64'd1);
      chk({name, " latency"}, 64'(lat), 64'(L + 1));
      chk({name, " data"}, data, exp);
   endtask

   task automatic run_op(input string name, input mult_op_t op, input logic sgn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
      flush = 1'b0; resp_ready = 1'b1;
      set_req(op, sgn, a, b);
      wait_accept(name);
      wait_resp(name, exp);
   endtask

   typedef struct {
      mult_op_t    op;
      logic        sgn;
      logic [63:0] a, b, exp;
   } vec_t;
   vec_t tbl [8];

   initial begin
      tbl[0] = '{MUL,  1'b0, 64'd3, 64'd5, 64'd15};
      tbl[1] = '{MULW, 1'b0, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
      tbl[2] = '{MUL,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9};
      tbl[3] = '{MULW, 1'b0, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_0000_0003, 64'hFFFF_FFFF_FFFF_FFFD};
      tbl[4] = '{MUL,  1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
      tbl[5] = '{MULW, 1'b1, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000};
      tbl[6] = '{MUL,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
      tbl[7] = '{MULW, 1'b0, 64'h0001_0000, 64'h0001_0000, 64'd0};

      reset = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      req_op = MUL; req_signed = 1'b0; req_a = '0; req_b = '0;
      cyc = 0;
      #3;
      chk("reset resp_valid", 64'(resp_valid), 64'd0);
      chk("reset resp_data", resp_data, 64'd0);
      chk("reset mul_a", mul_a, 64'd0);
      chk("reset mul_is_signed", 64'(mul_is_signed), 64'd0);
      #20 reset = 1'b1;
      model_reset();
      @(posedge clk); #1;

      // idle after reset
      for (int i = 0; i < 10; i++) cyc_step();

      // directed table
      for (int i = 0; i < 8; i++) run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp);

      // backpressure then back-to-back accept
      resp_ready = 1'b0;
      set_req(MUL, 1'b0, 64'd10, 64'd11);
      wait_accept("bp");
      begin
         bit got = 0;
         for (int i = 0; i < int'(L) + 8 && !got; i++) begin
            cyc_step();
            got = last_valid;
         end
         chk("bp resp seen", 64'(got), 64'd1);
      end
      set_req(MUL, 1'b0, 64'd2, 64'd2);
      for (int i = 0; i < 5; i++) begin
         cyc_step();
         chk("bp data stable", last_data, 64'd110);
         chk("bp req_ready low", 64'(last_ready), 64'd0);
      end
      resp_ready = 1'b1;
      cyc_step();
      chk("b2b accept", 64'(last_ready), 64'd1);
      req_valid = 1'b0;
      wait_resp("b2b", 64'd4);

      // flush in second BUSY cycle
      set_req(MUL, 1'b0, 64'd100, 64'd3);
      wait_accept("fl");
      cyc_step();
      flush = 1'b1;
      cyc_step();
      flush = 1'b0;
      for (int i = 0; i < int'(L) + 3; i++) cyc_step();
      run_op("after flush", MUL, 1'b0, 64'd6, 64'd7, 64'd42);

      // flush and req_valid in the same cycle
      flush = 1'b1;
      set_req(MUL, 1'b0, 64'd5, 64'd5);
      cyc_step();
      chk("flush blocks accept", 64'(last_ready), 64'd0);
      flush = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < int'(L) + 3; i++) cyc_step();

      // async reset in the middle of BUSY
      set_req(MULW, 1'b0, 64'h0000_0000_8765_4321, 64'd3);
      wait_accept("rst");
      cyc_step();
      #2 reset = 1'b0;
      #1;
      chk("midop resp_valid", 64'(resp_valid), 64'd0);
      chk("midop resp_data", resp_data, 64'd0);
      chk("midop mul_a", mul_a, 64'd0);
      chk("midop mul_b", mul_b, 64'd0);
      chk("midop mul_is_signed", 64'(mul_is_signed), 64'd0);
      #10 reset = 1'b1;
      model_reset();
      @(posedge clk); #1;
      cyc_step();
      run_op("after reset", MUL, 1'b0, 64'd9, 64'd9, 64'd81);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         req_valid  = 1'($urandom_range(0, 1));
         req_op     = mult_op_t'($urandom_range(0, 1));
         req_signed = 1'($urandom_range(0, 1));
         req_a      = {$urandom, $urandom};
         req_b      = {$urandom, $urandom};
         resp_ready = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         cyc_step();
      end
      flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) cyc_step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
